// File: rtl/ddrx_pkg.sv
// Shared types for the per-bank command path: command opcodes, sequencer states
// and the sizing rule for the timing down-counters.
package ddrx_pkg;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_PRE = 3'd2,
    CMD_RD  = 3'd3,
    CMD_WR  = 3'd4
  } bank_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRE    = 2'd1,
    ST_ACT    = 2'd2,
    ST_ACCESS = 2'd3
  } bank_state_e;

  localparam int TMR_TRCD = 0;
  localparam int TMR_TRP  = 1;
  localparam int TMR_TRAS = 2;
  localparam int TMR_TWR  = 3;
  localparam int TMR_NUM  = 4;

  // One shared width, wide enough for the largest timing value.
  function automatic int timing_cnt_width(input int trcd, input int trp,
                                          input int tras, input int twr);
    int m;
    m = trcd;
    if (trp > m) m = trp;
    if (tras > m) m = tras;
    if (twr > m) m = twr;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/timing_down_counter.sv
// Loadable down-counter that saturates at zero; zero means the guarded
// command may issue this cycle.
module timing_down_counter #(
  parameter int W = 4
) (
  input  logic         core_clk,
  input  logic         core_rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/bank_cmd_sequencer.sv
// Per-bank sequencer: turns row/col requests into PRE/ACT/RD/WR commands under
// tRCD/tRP/tRAS/tWR and keeps the bank manager's open-row state in step.
module bank_cmd_sequencer
  import ddrx_pkg::*;
#(
  parameter int C_ROW_WIDTH = 14,
  parameter int C_COL_WIDTH = 10,
  parameter int C_TRCD      = 4,
  parameter int C_TRP       = 4,
  parameter int C_TRAS      = 10,
  parameter int C_TWR       = 5
) (
  input  logic                   core_clk,
  input  logic                   core_rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [C_ROW_WIDTH-1:0] req_row,
  input  logic [C_COL_WIDTH-1:0] req_col,
  input  logic                   req_write,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [2:0]             cmd_op,
  output logic [C_ROW_WIDTH-1:0] cmd_row,
  output logic [C_COL_WIDTH-1:0] cmd_col,
  input  logic                   ref_req,
  output logic                   ref_ack,
  output logic                   update_row,
  output logic [C_ROW_WIDTH-1:0] new_row,
  output logic                   toggle_bank,
  input  logic [C_ROW_WIDTH-1:0] current_row,
  input  logic                   bank_open
);

  localparam int CNT_W = timing_cnt_width(C_TRCD, C_TRP, C_TRAS, C_TWR);

  bank_state_e            state_q, state_d;
  logic [C_ROW_WIDTH-1:0] row_q, row_d;
  logic [C_COL_WIDTH-1:0] col_q, col_d;
  logic                   write_q, write_d;
  logic                   refresh_q, refresh_d;
  logic                   settle_q, settle_d;
  logic                   update_row_q, update_row_d;
  logic                   toggle_bank_q, toggle_bank_d;
  logic [C_ROW_WIDTH-1:0] new_row_q, new_row_d;

  logic [TMR_NUM-1:0]     tmr_load;
  logic [TMR_NUM-1:0]     tmr_zero;
  logic [CNT_W-1:0]       tmr_load_val [TMR_NUM];
  logic                   cmd_fire;
  bank_cmd_e              cmd_op_e;

  assign tmr_load_val[TMR_TRCD] = CNT_W'(C_TRCD - 1);
  assign tmr_load_val[TMR_TRP]  = CNT_W'(C_TRP - 1);
  assign tmr_load_val[TMR_TRAS] = CNT_W'(C_TRAS - 1);
  assign tmr_load_val[TMR_TWR]  = CNT_W'(C_TWR - 1);

  genvar gi;
  generate
    for (gi = 0; gi < TMR_NUM; gi++) begin : g_tmr
      timing_down_counter #(.W(CNT_W)) u_cnt (
        .core_clk (core_clk),
        .core_rst (core_rst),
        .load     (tmr_load[gi]),
        .load_val (tmr_load_val[gi]),
        .zero     (tmr_zero[gi])
      );
    end
  endgenerate

  // Command presentation depends only on registered state and counters.
  always_comb begin
    cmd_valid = 1'b0;
    cmd_op_e  = CMD_NOP;
    case (state_q)
      ST_PRE: begin
        cmd_valid = tmr_zero[TMR_TRAS] && tmr_zero[TMR_TWR] && !settle_q;
        cmd_op_e  = CMD_PRE;
      end
      ST_ACT: begin
        cmd_valid = tmr_zero[TMR_TRP];
        cmd_op_e  = CMD_ACT;
      end
      ST_ACCESS: begin
        cmd_valid = tmr_zero[TMR_TRCD];
        cmd_op_e  = write_q ? CMD_WR : CMD_RD;
      end
      default: begin
        cmd_valid = 1'b0;
        cmd_op_e  = CMD_NOP;
      end
    endcase
  end

  assign cmd_fire = cmd_valid && cmd_ready;

  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    col_d         = col_q;
    write_d       = write_q;
    refresh_d     = refresh_q;
    settle_d      = 1'b0;
    update_row_d  = 1'b0;
    toggle_bank_d = 1'b0;
    new_row_d     = new_row_q;
    tmr_load      = '0;
    case (state_q)
      ST_IDLE: begin
        if (ref_req) begin
          if (bank_open) begin
            state_d   = ST_PRE;
            refresh_d = 1'b1;
          end
        end else if (req_valid) begin
          row_d     = req_row;
          col_d     = req_col;
          write_d   = req_write;
          refresh_d = 1'b0;
          if (!bank_open) begin
            state_d = ST_ACT;
          end else if (req_row == current_row) begin
            state_d = ST_ACCESS;
          end else begin
            state_d = ST_PRE;
          end
        end
      end
      ST_PRE: begin
        // A refresh close lingers one extra cycle so the toggle has reached
        // the bank manager before IDLE looks at bank_open again.
        if (settle_q) begin
          state_d = ST_IDLE;
        end else if (cmd_fire) begin
          toggle_bank_d     = 1'b1;
          tmr_load[TMR_TRP] = 1'b1;
          if (refresh_q) begin
            settle_d  = 1'b1;
            refresh_d = 1'b0;
          end else begin
            state_d = ST_ACT;
          end
        end
      end
      ST_ACT: begin
        if (cmd_fire) begin
          update_row_d       = 1'b1;
          toggle_bank_d      = 1'b1;
          new_row_d          = row_q;
          tmr_load[TMR_TRAS] = 1'b1;
          tmr_load[TMR_TRCD] = 1'b1;
          state_d            = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cmd_fire) begin
          tmr_load[TMR_TWR] = write_q;
          state_d           = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state_q       <= ST_IDLE;
      row_q         <= '0;
      col_q         <= '0;
      write_q       <= 1'b0;
      refresh_q     <= 1'b0;
      settle_q      <= 1'b0;
      update_row_q  <= 1'b0;
      toggle_bank_q <= 1'b0;
      new_row_q     <= '0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      write_q       <= write_d;
      refresh_q     <= refresh_d;
      settle_q      <= settle_d;
      update_row_q  <= update_row_d;
      toggle_bank_q <= toggle_bank_d;
      new_row_q     <= new_row_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE) && !ref_req && !core_rst;
  assign ref_ack     = ref_req && (state_q == ST_IDLE) && !bank_open &&
                       tmr_zero[TMR_TRP] && !core_rst;
  assign cmd_op      = cmd_op_e;
  assign cmd_row     = row_q;
  assign cmd_col     = col_q;
  assign update_row  = update_row_q;
  assign toggle_bank = toggle_bank_q;
  assign new_row     = new_row_q;

endmodule
